// File: rtl/tex_pkg.sv
// tex_pkg: shared state encoding and character constants for the tex text path
package tex_pkg;
   typedef enum logic [2:0] {IDLE, CAPTURE, EMIT_L, EMIT_SEP, EMIT_R, EMIT_EOL} state_e;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam int PAIR_W = 16;
endpackage

// File: rtl/tex_pair_ram.sv
// tex_pair_ram: DEPTH x PAIR_W register file, synchronous write, combinational read
module tex_pair_ram import tex_pkg::*; #(
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [PAIR_W-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [PAIR_W-1:0]        rdata_o
);
   logic [PAIR_W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/tex_line_emitter.sv
// tex_line_emitter: buffers one line of (lhs, rhs) pairs, then streams lhs, SEP, rhs, EOL.
// Optional trailing-space trimming per side when TEX_LINE_TRIM_EN is defined.
module tex_line_emitter import tex_pkg::*; #(
   parameter int         DEPTH    = 32,
   parameter logic [7:0] SEP_CHAR = ASCII_EQ,
   parameter logic [7:0] EOL_CHAR = ASCII_LF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] line_len,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] lhs,
   input  logic [7:0] rhs,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_char,
   output logic       out_last,
   output logic       busy,
   output logic       overflow
);
   localparam int         AW     = $clog2(DEPTH);
   localparam logic [6:0] DEPTH7 = 7'(DEPTH);
   state_e            state_q;
   logic [5:0]        len_q;
   logic [6:0]        idx_q, rd_q, stored, nl, nr;
   logic [7:0]        out_char_q;
   logic              out_valid_q, out_last_q, overflow_q;
   logic              beat, wr_en, last_beat, hs;
   logic [AW-1:0]     raddr;
   logic [PAIR_W-1:0] rdata, rpair;
   assign in_ready  = state_q == CAPTURE;
   assign beat      = in_valid && in_ready;
   assign wr_en     = beat && idx_q < DEPTH7;
   assign last_beat = beat && idx_q + 7'd1 == {1'b0, len_q};
   assign hs        = out_valid_q && out_ready;
   assign stored    = {1'b0, len_q} > DEPTH7 ? DEPTH7 : {1'b0, len_q};
   assign raddr     = (state_q == CAPTURE || state_q == EMIT_SEP) ? '0 : rd_q[AW-1:0];
   // a one-pair line writes slot 0 on the same edge that loads its first byte
   assign rpair     = (wr_en && idx_q == 7'd0) ? {lhs, rhs} : rdata;
   tex_pair_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (idx_q[AW-1:0]),
      .wdata_i ({lhs, rhs}),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );
`ifdef TEX_LINE_TRIM_EN
   logic [6:0] last_l_q, last_r_q;
   assign nl = (wr_en && lhs != ASCII_SPACE) ? idx_q + 7'd1 : last_l_q;
   assign nr = (wr_en && rhs != ASCII_SPACE) ? idx_q + 7'd1 : last_r_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         last_l_q <= '0;
         last_r_q <= '0;
      end else begin
         last_l_q <= state_q == IDLE ? 7'd0 : nl;
         last_r_q <= state_q == IDLE ? 7'd0 : nr;
      end
`else
   assign nl = stored;
   assign nr = stored;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         rd_q        <= '0;
         out_char_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               len_q      <= line_len;
               idx_q      <= '0;
               overflow_q <= 1'b0;
               if (line_len == 6'd0) begin
                  state_q     <= EMIT_SEP;
                  out_char_q  <= SEP_CHAR;
                  out_valid_q <= 1'b1;
               end else state_q <= CAPTURE;
            end
            CAPTURE: if (beat) begin
               idx_q <= idx_q + 7'd1;
               if (!wr_en) overflow_q <= 1'b1;
               if (last_beat) begin
                  out_valid_q <= 1'b1;
                  rd_q        <= 7'd1;
                  state_q     <= nl != 7'd0 ? EMIT_L : EMIT_SEP;
                  out_char_q  <= nl != 7'd0 ? rpair[15:8] : SEP_CHAR;
               end
            end
            EMIT_L: if (hs) begin
               rd_q       <= rd_q + 7'd1;
               state_q    <= rd_q < nl ? EMIT_L : EMIT_SEP;
               out_char_q <= rd_q < nl ? rdata[15:8] : SEP_CHAR;
            end
            EMIT_SEP: if (hs) begin
               rd_q       <= 7'd1;
               state_q    <= nr != 7'd0 ? EMIT_R : EMIT_EOL;
               out_char_q <= nr != 7'd0 ? rdata[7:0] : EOL_CHAR;
               out_last_q <= nr == 7'd0;
            end
            EMIT_R: if (hs) begin
               rd_q       <= rd_q + 7'd1;
               state_q    <= rd_q < nr ? EMIT_R : EMIT_EOL;
               out_char_q <= rd_q < nr ? rdata[7:0] : EOL_CHAR;
               out_last_q <= rd_q >= nr;
            end
            EMIT_EOL: if (hs) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   assign out_char  = out_char_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign overflow  = overflow_q;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_tex_line_emitter.sv
// tb_tex_line_emitter: scoreboard bench; stimulus pushes expected bytes, a monitor pops on each handshake
module tb_tex_line_emitter;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1, bp = 1'b0;
   logic [5:0] line_len = '0;
   logic [7:0] lhs = '0, rhs = '0;
   logic       in_ready, out_valid, out_last, busy, overflow;
   logic [7:0] out_char;
   int         checks = 0, errors = 0, pops = 0;
   logic [8:0] exp_q [$];
   logic [7:0] lv [8], rv [8];

   always #5 clk = ~clk;

   tex_line_emitter #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .line_len(line_len),
      .in_valid(in_valid), .in_ready(in_ready), .lhs(lhs), .rhs(rhs),
      .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
      .out_last(out_last), .busy(busy), .overflow(overflow)
   );

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_line(input int len);
      int st, nl, nr;
      st = len > 4 ? 4 : len;
      nl = st;
      nr = st;
`ifdef TEX_LINE_TRIM_EN
      nl = 0;
      nr = 0;
      for (int i = 0; i < st; i++) begin
         if (lv[i] != 8'h20) nl = i + 1;
         if (rv[i] != 8'h20) nr = i + 1;
      end
`endif
      for (int i = 0; i < nl; i++) exp_q.push_back({1'b0, lv[i]});
      exp_q.push_back({1'b0, 8'h3D});
      for (int i = 0; i < nr; i++) exp_q.push_back({1'b0, rv[i]});
      exp_q.push_back({1'b1, 8'h0A});
   endtask

   task automatic send_line(input int len);
      push_line(len);
      line_len = 6'(len);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("in_ready_after_start", 9'(in_ready), 9'(len > 0));
      check("busy_after_start", 9'(busy), 9'd1);
      for (int i = 0; i < len; i++) begin
         lhs      = lv[i];
         rhs      = rv[i];
         in_valid = 1'b1;
         check("in_ready_beat", 9'(in_ready), 9'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      lhs      = '0;
      rhs      = '0;
   endtask

   task automatic wait_done(input string name);
      int n;
      for (n = 0; n < 300 && exp_q.size() != 0; n++) begin
         @(negedge clk); #1;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: %0d bytes outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end else begin
         @(posedge clk); #1;
         check({name, "_busy_after_eol"}, 9'(busy), 9'd0);
         check({name, "_valid_after_eol"}, 9'(out_valid), 9'd0);
      end
   endtask

   task automatic wait_pops(input int target);
      int n;
      for (n = 0; n < 300 && pops < target; n++) begin
         @(negedge clk); #1;
      end
      if (pops < target) begin
         checks++;
         errors++;
         $display("FAIL pops_timeout: got %0d, expected %0d", pops, target);
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      out_ready = bp ? ~out_ready : 1'b1;
   end

   initial begin
      logic       held;
      logic [8:0] hv, e;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || !out_valid) held = 1'b0;
         else begin
            if (held) check("stall_hold", {out_last, out_char}, hv);
            if (out_ready) begin
               held = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %h, expected none", {out_last, out_char});
               end else begin
                  e = exp_q.pop_front();
                  check("out_byte", {out_last, out_char}, e);
                  pops++;
               end
            end else begin
               held = 1'b1;
               hv   = {out_last, out_char};
            end
         end
      end
   end

   initial begin
      int p0;
      #1;
      check("rst_out_valid", 9'(out_valid), 9'd0);
      check("rst_out_char", 9'(out_char), 9'd0);
      check("rst_in_ready", 9'(in_ready), 9'd0);
      check("rst_busy", 9'(busy), 9'd0);
      check("rst_overflow", 9'(overflow), 9'd0);
      check("rst_out_last", 9'(out_last), 9'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      lv[0] = 8'h31; lv[1] = 8'h73; rv[0] = 8'h31; rv[1] = 8'h20;
      send_line(2);
      wait_done("basic");
      for (int i = 0; i < 3; i++) begin lv[i] = 8'h20; rv[i] = 8'h20; end
      send_line(3);
      wait_done("spaces");
      send_line(0);
      wait_done("empty");
      for (int i = 0; i < 6; i++) begin lv[i] = 8'h41 + 8'(i); rv[i] = 8'h61 + 8'(i); end
      send_line(6);
      check("overflow_set", 9'(overflow), 9'd1);
      wait_done("overflow");
      check("overflow_sticky", 9'(overflow), 9'd1);
      bp = 1'b1;
      lv[0] = 8'h31; lv[1] = 8'h73; rv[0] = 8'h31; rv[1] = 8'h20;
      send_line(2);
      check("overflow_cleared", 9'(overflow), 9'd0);
      wait_done("backpressure");
      bp = 1'b0;
      @(posedge clk); #1;
      p0 = pops;
      send_line(2);
      wait_pops(p0 + 2);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 9'(out_valid), 9'd0);
      check("midrst_out_char", 9'(out_char), 9'd0);
      check("midrst_out_last", 9'(out_last), 9'd0);
      check("midrst_busy", 9'(busy), 9'd0);
      check("midrst_in_ready", 9'(in_ready), 9'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      send_line(2);
      wait_done("after_reset");
      for (int i = 0; i < 3; i++) begin lv[i] = 8'h41 + 8'(i); rv[i] = 8'h61 + 8'(i); end
      p0 = pops;
      send_line(3);
      wait_pops(p0 + 4);
      line_len = 6'd1;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("start_in_emit_r");
      @(posedge clk); #1;
      check("ignored_start_in_ready", 9'(in_ready), 9'd0);
      check("ignored_start_busy", 9'(busy), 9'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
